matmul_acc_stream: RTL and testbench
====================================

Name: matmul_acc_stream

Overview:
- Parametrised successor to the fixed 4x4 16-bit outer-product matmul engine.
- Accumulates `acc[i][j] += a[i]*b[j]` over a stream of operand-vector pairs, producing an N x N result.
- Drains the result one row per beat over a valid/ready handshake.
- Sits between the operand fetch units and the result writeback buffer.

Parameters:
- N, 4: matrix dimension (lanes per operand vector; rows and columns of the result).
- DW, 16: operand lane width.
- ACC_W, 32: accumulator and output lane width, ACC_W >= 2*DW.
- SIGNED, 0: 1 = two's-complement operands and accumulators; 0 = unsigned.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  2  command: 00 NOP, 01 CLEAR, 10 ACC, 11 DRAIN.
- in_valid  in  1  qualifies op/a/b this cycle.
- in_ready  out  1  block accepts op this cycle.
- a  in  N*DW  column vector; lane i = bits [i*DW +: DW].
- b  in  N*DW  row vector; lane j = bits [j*DW +: DW].
- out_valid  out  1  out_row holds a valid result row.
- out_ready  in  1  downstream accepts the row.
- out_row  out  N*ACC_W  result row; lane j = acc[out_idx][j].
- out_idx  out  clog2(N)  index of the row being presented.
- out_last  out  1  high on row N-1 of a drain.
- busy  out  1  drain in progress.

Behaviour:
- Reset (rst low, async): all acc = 0, state IDLE, out_valid = 0, out_row = 0, out_idx = 0, out_last = 0, busy = 0, in_ready = 1.
- States: IDLE and DRAIN. in_ready = (state == IDLE).
- A command is accepted when in_valid && in_ready. Unaccepted cycles change nothing.
- IDLE, accepted ACC:
  - next edge: acc[i][j] <= acc[i][j] + a[i]*b[j] for all i, j.
  - Products are 2*DW wide, sign- or zero-extended to ACC_W per SIGNED.
  - Sums wrap modulo 2^ACC_W.
  - One ACC per cycle; back-to-back ACCs are fully pipelined with no bubbles.
- IDLE, accepted CLEAR: next edge all acc = 0.
- IDLE, accepted NOP: no effect.
- IDLE, accepted DRAIN:
  - next edge: state DRAIN, busy = 1, out_idx = 0, out_valid = 1.
  - Accumulator contents are frozen for the whole drain.
- DRAIN:
  - out_row is combinationally selected from acc[out_idx].
  - On out_valid && out_ready: out_idx increments.
  - When the handshake completes on out_idx == N-1 (out_last = 1): next edge state IDLE, out_valid = 0, busy = 0, out_idx = 0.
  - Accumulators are NOT cleared by a drain; issue CLEAR explicitly.
  - out_valid must not drop, and out_row must not change, while out_ready is low.
- Commands arriving during DRAIN are not accepted (in_ready = 0); the source must hold them.
- Minimum drain latency: the first row is visible 1 cycle after DRAIN is accepted; N beats with out_ready held high.
- Reset asserted mid-ACC or mid-DRAIN: immediate return to reset values; the partial drain is abandoned.
- N = 1: the drain is a single beat, with out_last = 1 on that beat.

Optional Feature:
- MATMUL_ACC_SAT_EN defined:
  - Every accumulate saturates to the ACC_W range instead of wrapping.
  - Signed range: [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Unsigned range: [0, 2^ACC_W-1].
  - Adds a sticky output `sat_flag` (1 bit) set by any saturating lane, cleared by CLEAR or reset.
- Undefined: modulo-2^ACC_W wrap; the sat_flag port is absent.

Decomposition:
- Package matmul_pkg holds:
  - the op encoding constants OP_NOP/OP_CLEAR/OP_ACC/OP_DRAIN;
  - the state enum {ST_IDLE, ST_DRAIN};
  - a function for the sign/zero extension of products to ACC_W.
- Sub-module matmul_pe: one accumulator cell with ports clk, rst, acc_en, clr, a_lane, b_lane, acc_q, and sat under the macro.
- The top instantiates an N x N generate array of matmul_pe plus the drain FSM and the row mux.

Test Plan:
- Reset: pulse rst low during an ACC stream, then DRAIN -> 4 rows all zero; busy = 0 and in_ready = 1 after reset.
- Basic 4x4 (N=4, DW=16, ACC_W=32, unsigned), fed with 4 ACC beats:
  - a lanes {1,5,9,13}, {2,6,10,14}, {3,7,11,15}, {4,8,12,16};
  - b lanes {17..20}, {21..24}, {25..28}, {29..32};
  - then DRAIN -> rows [250,260,270,280], [618,644,670,696], [986,1028,1070,1112], [1354,1412,1470,1528];
  - out_last only on row 3.
- Backpressure: repeat the basic test with out_ready toggled 1,0,0,1,0,1,1 -> same 4 rows in order; out_row stable while stalled; in_ready = 0 for the whole drain.
- Accumulate without clear, then clear:
  - Second basic-test stream with no CLEAR -> every result doubles (row 0 = [500,520,540,560]).
  - CLEAR, then the stream again -> original values.
- Command during drain: hold in_valid = 1 with op = ACC while busy -> not accepted, acc unchanged; it is accepted on the first IDLE cycle.
- Saturation (SIGNED=1): 3 ACC beats of a[0] = b[0] = 32767, then DRAIN:
  - with MATMUL_ACC_SAT_EN: lane 0 of row 0 = 2147483647 and sat_flag = 1;
  - without it: lane 0 of row 0 = -1073938429.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the streaming outer-product matmul engine.
//   - op encodings (OP_NOP / OP_CLEAR / OP_ACC / OP_DRAIN)
//   - drain FSM state enum
//   - ext_prod(): sign/zero extension of a 2*DW product toward ACC_W
// Optional build macro used by the rest of the slice: MATMUL_ACC_SAT_EN.
package matmul_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_ACC   = 2'b10;
    localparam logic [1:0] OP_DRAIN = 2'b11;

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    // Widest product / accumulator the helper handles; callers truncate.
    localparam int EXT_MAX_W = 256;

    // Extend the low pw bits of p to EXT_MAX_W, replicating bit pw-1 when sgn.
    function automatic logic [EXT_MAX_W-1:0] ext_prod(input logic [EXT_MAX_W-1:0] p,
                                                      input int pw,
                                                      input logic sgn);
        logic [EXT_MAX_W-1:0] mask;
        logic [EXT_MAX_W-1:0] sh;
        logic                 msb;
        mask = (EXT_MAX_W'(1) << pw) - EXT_MAX_W'(1);
        sh   = p >> (pw - 1);
        msb  = sgn & sh[0];
        return msb ? (p | ~mask) : (p & mask);
    endfunction

endpackage

// File: rtl/matmul_pe.sv
// matmul_pe: one accumulator cell, acc_q <= acc_q + a_lane*b_lane.
// Ports:
//   clk, rst     clock / async active-low reset
//   acc_en       add this cycle's product
//   clr          zero the accumulator (wins over acc_en)
//   a_lane       DW-bit operand from the column vector
//   b_lane       DW-bit operand from the row vector
//   acc_q        ACC_W-bit accumulator
//   sat          (MATMUL_ACC_SAT_EN only) this cycle's accumulate clamped
// Default build wraps modulo 2^ACC_W; with MATMUL_ACC_SAT_EN it saturates.
module matmul_pe
    import matmul_pkg::*;
#(
    parameter int DW     = 16,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_en,
    input  logic             clr,
    input  logic [DW-1:0]    a_lane,
    input  logic [DW-1:0]    b_lane,
    output logic [ACC_W-1:0] acc_q
`ifdef MATMUL_ACC_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic SGN = (SIGNED != 0);

    logic [2*DW-1:0]  ax, bx, prod;
    logic [ACC_W-1:0] prod_ext, acc_d;

    // Extending both operands to 2*DW first makes the low 2*DW bits of the
    // product correct for both signed and unsigned operands.
    assign ax       = {{DW{SGN & a_lane[DW-1]}}, a_lane};
    assign bx       = {{DW{SGN & b_lane[DW-1]}}, b_lane};
    assign prod     = ax * bx;
    assign prod_ext = ACC_W'(ext_prod(EXT_MAX_W'(prod), 2 * DW, SGN));

`ifdef MATMUL_ACC_SAT_EN
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] sum, sat_val;
    logic             ovf;

    assign sum_w = {1'b0, acc_q} + {1'b0, prod_ext};
    assign sum   = sum_w[ACC_W-1:0];

    always_comb begin
        ovf     = 1'b0;
        sat_val = '1;
        if (SGN) begin
            // Signed overflow: operands agree in sign, result does not.
            ovf     = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
            sat_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            // Unsigned products are non-negative, so only the top can clip.
            ovf     = sum_w[ACC_W];
            sat_val = '1;
        end
    end

    assign acc_d = ovf ? sat_val : sum;
    assign sat   = acc_en & ovf;
`else
    assign acc_d = acc_q + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        acc_q <= '0;
        else if (clr)    acc_q <= '0;
        else if (acc_en) acc_q <= acc_d;
    end

endmodule

// File: rtl/matmul_acc_stream.sv
// matmul_acc_stream: N x N outer-product accumulator with row-wise drain.
// Ports:
//   clk, rst              clock / async active-low reset
//   op, in_valid, in_ready command handshake (NOP/CLEAR/ACC/DRAIN)
//   a, b                  N lanes of DW bits (lane i at [i*DW +: DW])
//   out_valid, out_ready  result-row handshake
//   out_row               N lanes of ACC_W bits, row acc[out_idx]
//   out_idx, out_last     row index / final row marker
//   busy                  drain in progress
//   sat_flag              (MATMUL_ACC_SAT_EN only) sticky saturation flag
// Optional build macro: MATMUL_ACC_SAT_EN (saturating accumulate + sat_flag).
module matmul_acc_stream
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         op,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*DW-1:0]    a,
    input  logic [N*DW-1:0]    b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*ACC_W-1:0] out_row,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               busy
`ifdef MATMUL_ACC_SAT_EN
    ,
    output logic               sat_flag
`endif
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              accept, acc_en, clr;

    logic [N-1:0][N-1:0][ACC_W-1:0] acc;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_DRAIN);
    assign out_valid = busy;
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == IDX_W'(N - 1));

    // Commands are only accepted in IDLE, which also freezes acc during a drain.
    assign accept = in_valid && in_ready;
    assign acc_en = accept && (op == OP_ACC);
    assign clr    = accept && (op == OP_CLEAR);

`ifdef MATMUL_ACC_SAT_EN
    logic [N-1:0][N-1:0] pe_sat;
`endif

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            matmul_pe #(
                .DW     (DW),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .acc_en (acc_en),
                .clr    (clr),
                .a_lane (a[i*DW +: DW]),
                .b_lane (b[j*DW +: DW]),
                .acc_q  (acc[i][j])
`ifdef MATMUL_ACC_SAT_EN
                ,
                .sat    (pe_sat[i][j])
`endif
            );
        end
    end

`ifdef MATMUL_ACC_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         sat_flag <= 1'b0;
        else if (clr)     sat_flag <= 1'b0;
        else if (|pe_sat) sat_flag <= 1'b1;
    end
`endif

    // Row mux; forced to zero outside a drain so idle output is quiet.
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int r = 0; r < N; r++) begin
                if (idx_q == IDX_W'(r)) out_row = acc[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (accept && (op == OP_DRAIN)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_acc_stream.sv
module tb_matmul_acc_stream;
    import matmul_pkg::*;

    logic clk, rst;

    // main DUT: N=4, DW=16, ACC_W=32, unsigned
    logic [1:0]   op;
    logic         in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [63:0]  a, b;
    logic [127:0] out_row;
    logic [1:0]   out_idx;

    // signed DUT for saturation / wrap
    logic [1:0]   s_op;
    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy;
    logic [63:0]  s_a, s_b;
    logic [127:0] s_out_row;
    logic [1:0]   s_out_idx;

    // N=1 DUT
    logic [1:0]   o_op;
    logic         o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_out_last, o_busy;
    logic [7:0]   o_a, o_b;
    logic [15:0]  o_out_row;
    logic [0:0]   o_out_idx;

`ifdef MATMUL_ACC_SAT_EN
    logic sat_flag, s_sat_flag, o_sat_flag;
`endif

    matmul_acc_stream #(.N(4), .DW(16), .ACC_W(32), .SIGNED(0)) dut (
        .clk(clk), .rst(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_idx(out_idx), .out_last(out_last), .busy(busy)
`ifdef MATMUL_ACC_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    matmul_acc_stream #(.N(4), .DW(16), .ACC_W(32), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .op(s_op), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_row(s_out_row), .out_idx(s_out_idx), .out_last(s_out_last), .busy(s_busy)
`ifdef MATMUL_ACC_SAT_EN
        , .sat_flag(s_sat_flag)
`endif
    );

    matmul_acc_stream #(.N(1), .DW(8), .ACC_W(16), .SIGNED(0)) dut_o (
        .clk(clk), .rst(rst), .op(o_op), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .a(o_a), .b(o_b), .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_row(o_out_row), .out_idx(o_out_idx), .out_last(o_out_last), .busy(o_busy)
`ifdef MATMUL_ACC_SAT_EN
        , .sat_flag(o_sat_flag)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp_row;
    } vec_t;

    vec_t         tbl[4];
    logic [127:0] exp_rows[4];
    bit           bp_pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    function automatic logic [63:0] p16(input int x0, input int x1, input int x2, input int x3);
        return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    endfunction

    function automatic logic [127:0] p32(input int x0, input int x1, input int x2, input int x3);
        return {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
    endfunction

    function automatic logic [127:0] scale(input logic [127:0] r, input int k);
        logic [127:0] o;
        for (int j = 0; j < 4; j++) o[j*32 +: 32] = r[j*32 +: 32] * 32'(k);
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = OP_NOP;
    endtask

    task automatic stream();
        for (int k = 0; k < 4; k++) cmd(OP_ACC, tbl[k].a, tbl[k].b);
    endtask

    task automatic set_exp(input int k);
        for (int r = 0; r < 4; r++) exp_rows[r] = scale(tbl[r].exp_row, k);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},      128'(busy), 128'(0));
        chk({tag, "_in_ready"},  128'(in_ready), 128'(1));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_row"},   out_row, 128'(0));
        chk({tag, "_out_idx"},   128'(out_idx), 128'(0));
        chk({tag, "_out_last"},  128'(out_last), 128'(0));
    endtask

    task automatic drain_check(input string tag, input bit bp);
        int r   = 0;
        int cyc = 0;
        cmd(OP_DRAIN, '0, '0);
        while (r < 4 && cyc < 40) begin
            out_ready = bp ? ((cyc < 7) ? bp_pat[cyc] : 1'b1) : 1'b1;
            @(negedge clk);
            chk({tag, "_valid"},    128'(out_valid), 128'(1));
            chk({tag, "_idx"},      128'(out_idx), 128'(r));
            chk({tag, "_row"},      out_row, exp_rows[r]);
            chk({tag, "_last"},     128'(out_last), 128'(r == 3));
            chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
            chk({tag, "_busy"},     128'(busy), 128'(1));
            @(posedge clk); #1;
            if (out_ready) r++;
            cyc++;
        end
        chk({tag, "_timeout"}, 128'(r), 128'(4));
        out_ready = 1'b1;
        @(negedge clk);
        check_idle({tag, "_end"});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; s_in_valid = 1'b0; o_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] s_exp;
        tbl[0] = '{a: p16(1, 5, 9, 13),  b: p16(17, 18, 19, 20), exp_row: p32(250, 260, 270, 280)};
        tbl[1] = '{a: p16(2, 6, 10, 14), b: p16(21, 22, 23, 24), exp_row: p32(618, 644, 670, 696)};
        tbl[2] = '{a: p16(3, 7, 11, 15), b: p16(25, 26, 27, 28), exp_row: p32(986, 1028, 1070, 1112)};
        tbl[3] = '{a: p16(4, 8, 12, 16), b: p16(29, 30, 31, 32), exp_row: p32(1354, 1412, 1470, 1528)};

        op = OP_NOP; a = '0; b = '0; out_ready = 1'b1; in_valid = 1'b0;
        s_op = OP_NOP; s_a = '0; s_b = '0; s_out_ready = 1'b1; s_in_valid = 1'b0;
        o_op = OP_NOP; o_a = '0; o_b = '0; o_out_ready = 1'b1; o_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_idle("rst_async");
        do_reset();
        @(negedge clk);
        check_idle("rst");
        @(posedge clk); #1;

        // reset in the middle of an ACC stream
        cmd(OP_ACC, tbl[0].a, tbl[0].b);
        op = OP_ACC; a = tbl[1].a; b = tbl[1].b; in_valid = 1'b1;
        #2 rst = 1'b0;
        #1 check_idle("rst_mid_acc");
        in_valid = 1'b0; op = OP_NOP;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        set_exp(0);
        drain_check("zero", 1'b0);

        // basic stream
        stream();
        set_exp(1);
        drain_check("basic", 1'b0);

        // backpressure on a freshly cleared, re-streamed matrix
        cmd(OP_CLEAR, '0, '0);
        stream();
        drain_check("bp", 1'b1);

        // no clear: results double
        stream();
        set_exp(2);
        chk("dbl_row0_exp", exp_rows[0], p32(500, 520, 540, 560));
        drain_check("double", 1'b0);

        // clear, NOP, stream again: original values
        cmd(OP_CLEAR, '0, '0);
        cmd(OP_NOP, tbl[3].a, tbl[3].b);
        stream();
        set_exp(1);
        drain_check("cleared", 1'b0);

        // ACC held during a drain is accepted on the first IDLE cycle
        cmd(OP_DRAIN, '0, '0);
        op = OP_ACC; a = p16(1, 0, 0, 0); b = p16(1, 0, 0, 0); in_valid = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_row", out_row, exp_rows[r]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("hold_idle_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; op = OP_NOP;
        exp_rows[0] = exp_rows[0] + 128'(1);
        drain_check("held_acc", 1'b0);

        // reset in the middle of a drain
        cmd(OP_DRAIN, '0, '0);
        @(posedge clk); #1;
        chk("mid_drain_idx", 128'(out_idx), 128'(1));
        #2 rst = 1'b0;
        #1 check_idle("rst_mid_drain");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        set_exp(0);
        drain_check("post_rst", 1'b0);

`ifdef MATMUL_ACC_SAT_EN
        chk("sat_flag_unsigned", 128'(sat_flag), 128'(0));
`endif

        // signed: 3 * 32767^2 overflows 32 bits
        s_op = OP_ACC; s_a = p16(32767, 0, 0, 0); s_b = p16(32767, 0, 0, 0); s_in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        s_op = OP_DRAIN;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_op = OP_NOP;
        @(negedge clk);
`ifdef MATMUL_ACC_SAT_EN
        s_exp = 32'd2147483647;
        chk("s_sat_flag", 128'(s_sat_flag), 128'(1));
`else
        s_exp = 32'hBFFD0003;
`endif
        chk("s_valid", 128'(s_out_valid), 128'(1));
        chk("s_row0_lane0", 128'(s_out_row[31:0]), 128'(s_exp));
        chk("s_row0_lane1", 128'(s_out_row[63:32]), 128'(0));
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("s_idle", 128'(s_busy), 128'(0));
        @(posedge clk); #1;

        // N = 1: single-beat drain with out_last
        o_op = OP_ACC; o_a = 8'd3; o_b = 8'd5; o_in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        o_op = OP_DRAIN;
        @(posedge clk); #1;
        o_in_valid = 1'b0; o_op = OP_NOP; o_out_ready = 1'b0;
        @(negedge clk);
        chk("one_valid", 128'(o_out_valid), 128'(1));
        chk("one_last",  128'(o_out_last), 128'(1));
        chk("one_idx",   128'(o_out_idx), 128'(0));
        chk("one_row",   128'(o_out_row), 128'(30));
        @(posedge clk); #1;
        o_out_ready = 1'b1;
        @(negedge clk);
        chk("one_stall_valid", 128'(o_out_valid), 128'(1));
        chk("one_stall_row",   128'(o_out_row), 128'(30));
        @(posedge clk); #1;
        @(negedge clk);
        chk("one_done_valid", 128'(o_out_valid), 128'(0));
        chk("one_done_ready", 128'(o_in_ready), 128'(1));
        chk("one_done_busy",  128'(o_busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
